// File: rtl/e_md_unit.sv
// +--------------------------------------------------------------------------+
// | e_md_unit : execute-stage multiply/divide unit owning HI/LO              |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module e_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [3:0] c_mult_cycles = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cycles  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_count;
  logic [3:0]  w_count_nxt;
  logic        w_load;
  logic        w_commit;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mult;
  logic        w_is_div;
  logic        w_div_zero;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_rs;
  logic [31:0] w_abs_rt;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_is_mult  = (op == c_op_mult) || (op == c_op_multu);
  assign w_is_div   = (op == c_op_div)  || (op == c_op_divu);
  assign w_div_zero = (rt_val == 32'd0);

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
  assign w_abs_rs  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign w_abs_rt  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign w_dvd     = (op == c_op_div) ? w_abs_rs : rs_val;
  assign w_dvs     = w_div_zero ? 32'd1 : ((op == c_op_div) ? w_abs_rt : rt_val);
  assign w_quo_mag = w_dvd / w_dvs;
  assign w_rem_mag = w_dvd % w_dvs;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (op)
      c_op_mult: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      c_op_multu: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      c_op_div: begin
        w_res_lo = (rs_val[31] ^ rt_val[31]) ? (~w_quo_mag + 32'd1) : w_quo_mag;
        w_res_hi = rs_val[31] ? (~w_rem_mag + 32'd1) : w_rem_mag;
      end
      c_op_divu: begin
        w_res_lo = w_quo_mag;
        w_res_hi = w_rem_mag;
      end
      default: begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (w_is_mult || w_is_div)) begin
          w_load      = 1'b1;
          w_count_nxt = w_is_div ? c_div_cycles : c_mult_cycles;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_count_nxt = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_load) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_we <= !(w_is_div && w_div_zero);
      end
      if (w_commit && r_pend_we) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if ((r_state == S_IDLE) && start && (op == c_op_mthi)) begin
        r_hi <= rs_val;
      end
      if ((r_state == S_IDLE) && start && (op == c_op_mtlo)) begin
        r_lo <= rs_val;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/e_md_unit.md
Name: e_md_unit

Overview:
- Multiply/divide unit in the execute stage of the 5-stage MIPS pipeline.
- Consumes the operand values and decoded operation held by the D/E pipeline register.
- Owns the architectural HI/LO registers and emulates multi-cycle mult/div latency with a down-counter.
- Exports busy so the hazard unit can stall md-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu; legal range 1..15.
- DIV_CYCLES, 10, busy duration for div/divu; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; clock clk.
- start  input  1  one-cycle request, valid while the md instruction is in E.
- op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (no-op).
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mt source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  architectural HI (mfhi source).
- lo  output  32  architectural LO (mflo source).

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending results=0; overrides every other input in that cycle.
- States:
  - IDLE (counter==0, busy=0).
  - RUN (counter>0, busy=1).
- IDLE with start=1 and op in 1..4:
  - Compute the 64-bit result combinationally from rs_val/rt_val.
  - Latch it into pending_hi/pending_lo and load the counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN at the next edge.
- RUN: counter decrements each edge. On the edge where counter goes 1->0, hi/lo <= pending and busy drops.
- Timing:
  - busy is high for exactly N cycles, starting the cycle after start.
  - New hi/lo are visible in the first cycle busy=0.
- hi/lo never change while busy=1; they keep their old values for the whole RUN phase.
- MTHI/MTLO in IDLE: hi (or lo) <= rs_val at the same edge. Single-cycle, busy stays 0. The other register is untouched.
- start=1 with op 0 or 7: no effect.
- start=1 while busy=1, any op: ignored, pending and counter unchanged. The hazard unit guarantees this does not occur; the bench still checks it.
- Arithmetic:
  - MULT: signed 32x32->64. hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: unsigned 32x32->64. hi=upper 32 bits, lo=lower 32 bits.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0 (32-bit wrap, no trap).
- Divide by zero (DIV/DIVU, rt_val==0): full DIV_CYCLES busy period runs, but hi/lo are not written at completion.
- Reset mid-RUN: busy drops next edge, pending result is discarded, hi=lo=0.
- No flush input. A started operation always completes unless reset.

Test Plan:
- Reset held 2 cycles, then released -> hi=0, lo=0, busy=0. start with op=1 while reset=1 -> still all zero after reset drops.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy=1 for exactly 5 cycles after start; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. hi/lo hold their old values during busy.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
  - DIVU rs=0xFFFFFFF9, rt=2 -> after 10 cycles lo=0x7FFFFFFC, hi=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIV with rt=0 after hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22.
- MTHI rs=0xABCD0000 -> hi updates next edge, busy stays 0, lo unchanged.
  - MTLO issued mid-MULT -> ignored; final lo equals the MULT result.
- Reset asserted on the 3rd busy cycle of a DIV -> next cycle busy=0, hi=lo=0. No late write-back ever appears.
